// File: rtl/axis_stall_detector.sv
// AXI-Stream stall detector: per-channel stall counters and FSMs drive axis_block_sigs, plus a one-entry first-block report.
// Define STALL_MAX_EN to add max_stall_o/max_ch_o tracking of the largest stall count seen since reset/clear.

module axis_stall_ch #(
    parameter int unsigned CNT_W = 16,
    parameter bit          DIR   = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             tvalid_i,
    input  logic             tready_i,
    input  logic             inst_idle_i,
    input  logic [CNT_W-1:0] thr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             blocked_o,
    output logic             event_o
);
    typedef enum logic [1:0] {S_IDLE, S_STALL, S_BLOCKED} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             blocked_q;
    logic             stall;
    logic             active;

    // A sink stalls when the instance is ready but nothing arrives; a source when it offers data nobody takes.
    assign stall   = DIR ? (tready_i & ~tvalid_i) : (tvalid_i & ~tready_i);
    assign active  = stall & ~inst_idle_i;
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign event_o = (state_q == S_STALL) && active && (cnt_q >= thr_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            blocked_q <= 1'b0;
        end else if (clear_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            blocked_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (active) begin
                        state_q <= S_STALL;
                        cnt_q   <= CNT_W'(1);
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                S_STALL: begin
                    if (!active) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (cnt_q >= thr_i) begin
                            state_q   <= S_BLOCKED;
                            blocked_q <= 1'b1;
                        end
                    end
                end
                S_BLOCKED: begin
                    if (!active) begin
                        state_q   <= S_IDLE;
                        cnt_q     <= '0;
                        blocked_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    cnt_q     <= '0;
                    blocked_q <= 1'b0;
                end
            endcase
        end
    end

    assign cnt_o     = cnt_q;
    assign blocked_o = blocked_q;
endmodule

module axis_stall_detector #(
    parameter int unsigned       NUM_CH = 4,
    parameter int unsigned       CNT_W  = 16,
    parameter logic [NUM_CH-1:0] CH_DIR = '0,
    parameter int unsigned       CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] tvalid_i,
    input  logic [NUM_CH-1:0] tready_i,
    input  logic              inst_idle_i,
    input  logic [CNT_W-1:0]  thresh_i,
    input  logic              clear_i,
    output logic [NUM_CH-1:0] axis_block_sigs_o,
    output logic              report_valid_o,
    input  logic              report_ready_i,
    output logic [CH_W-1:0]   report_ch_o,
    output logic [CNT_W-1:0]  report_cycles_o,
    output logic              report_ovf_o
`ifdef STALL_MAX_EN
    ,
    output logic [CNT_W-1:0]  max_stall_o,
    output logic [CH_W-1:0]   max_ch_o
`endif
);
    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [CNT_W-1:0] cycles;
    } rpt_t;

    logic [CNT_W-1:0]             thr;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt;
    logic [NUM_CH-1:0]            blocked;
    logic [NUM_CH-1:0]            ev;
    logic                         multi;
    logic [CH_W-1:0]              sel_ch;
    logic [CNT_W-1:0]             sel_cnt;
    logic                         found;

    rpt_t rpt_q, rpt_d;
    logic valid_q, valid_d;
    logic ovf_q, ovf_d;

    assign thr = (thresh_i == '0) ? CNT_W'(1) : thresh_i;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        axis_stall_ch #(
            .CNT_W (CNT_W),
            .DIR   (CH_DIR[g])
        ) u_ch (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .clear_i     (clear_i),
            .tvalid_i    (tvalid_i[g]),
            .tready_i    (tready_i[g]),
            .inst_idle_i (inst_idle_i),
            .thr_i       (thr),
            .cnt_o       (cnt[g]),
            .blocked_o   (blocked[g]),
            .event_o     (ev[g])
        );
    end

    // Lowest-index event wins the report slot.
    always_comb begin
        sel_ch  = '0;
        sel_cnt = '0;
        found   = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (ev[i] && !found) begin
                found   = 1'b1;
                sel_ch  = CH_W'(i);
                sel_cnt = cnt[i];
            end
        end
    end

    assign multi = (ev & (ev - NUM_CH'(1))) != '0;

    // An accept frees the slot in the same cycle, so a coincident event is captured rather than lost.
    always_comb begin
        valid_d = valid_q;
        rpt_d   = rpt_q;
        ovf_d   = ovf_q;
        if (found) begin
            if (!valid_q || report_ready_i) begin
                valid_d      = 1'b1;
                rpt_d.ch     = sel_ch;
                rpt_d.cycles = sel_cnt;
                if (multi) ovf_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && report_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rpt_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (clear_i) begin
            rpt_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            rpt_q   <= rpt_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign axis_block_sigs_o = blocked;
    assign report_valid_o    = valid_q;
    assign report_ch_o       = rpt_q.ch;
    assign report_cycles_o   = rpt_q.cycles;
    assign report_ovf_o      = ovf_q;

`ifdef STALL_MAX_EN
    logic [CNT_W-1:0] max_q, max_d;
    logic [CH_W-1:0]  max_ch_q, max_ch_d;

    // Strict compare keeps equal values from moving the record and favours the lowest index on ties.
    always_comb begin
        max_d    = max_q;
        max_ch_d = max_ch_q;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (cnt[i] > max_d) begin
                max_d    = cnt[i];
                max_ch_d = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            max_q    <= '0;
            max_ch_q <= '0;
        end else if (clear_i) begin
            max_q    <= '0;
            max_ch_q <= '0;
        end else begin
            max_q    <= max_d;
            max_ch_q <= max_ch_d;
        end
    end

    assign max_stall_o = max_q;
    assign max_ch_o    = max_ch_q;
`endif
endmodule

// File: tb/tb_axis_stall_detector.sv
// Scoreboard bench for axis_stall_detector: run-length reference model feeds an expected-report queue checked by a monitor.

module tb_axis_stall_detector;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 4;
    localparam int CH_W   = 2;
    localparam logic [NUM_CH-1:0] CH_DIR = 4'b1010;
    localparam int MAXC = (1 << CNT_W) - 1;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NUM_CH-1:0] tvalid_i, tready_i;
    logic              inst_idle_i;
    logic [CNT_W-1:0]  thresh_i;
    logic              clear_i;
    logic [NUM_CH-1:0] axis_block_sigs_o;
    logic              report_valid_o;
    logic              report_ready_i;
    logic [CH_W-1:0]   report_ch_o;
    logic [CNT_W-1:0]  report_cycles_o;
    logic              report_ovf_o;

    axis_stall_detector #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .CH_DIR (CH_DIR),
        .CH_W   (CH_W)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .tvalid_i          (tvalid_i),
        .tready_i          (tready_i),
        .inst_idle_i       (inst_idle_i),
        .thresh_i          (thresh_i),
        .clear_i           (clear_i),
        .axis_block_sigs_o (axis_block_sigs_o),
        .report_valid_o    (report_valid_o),
        .report_ready_i    (report_ready_i),
        .report_ch_o       (report_ch_o),
        .report_cycles_o   (report_cycles_o),
        .report_ovf_o      (report_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a channel is blocked once it has been stalled for more than thr consecutive samples.
    typedef struct {
        int ch;
        int cyc;
    } rpt_t;

    rpt_t sbq[$];
    int   run [NUM_CH];
    bit   blk [NUM_CH];
    bit   m_rv, m_ovf;

    always @(posedge clk_i or negedge rst_ni) begin
        int   thr, nev, first, fcyc;
        bit   accept, act;
        rpt_t r;
        if (!rst_ni || clear_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
                run[i] = 0;
                blk[i] = 1'b0;
            end
            m_rv  = 1'b0;
            m_ovf = 1'b0;
            sbq.delete();
        end else begin
            thr    = (thresh_i == 0) ? 1 : int'(thresh_i);
            accept = m_rv && report_ready_i;
            nev    = 0;
            first  = -1;
            fcyc   = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                act = (CH_DIR[i] ? (tready_i[i] && !tvalid_i[i]) : (tvalid_i[i] && !tready_i[i])) && !inst_idle_i;
                if (act) begin
                    if (!blk[i] && run[i] >= thr) begin
                        nev++;
                        blk[i] = 1'b1;
                        if (first < 0) begin
                            first = i;
                            fcyc  = (run[i] > MAXC) ? MAXC : run[i];
                        end
                    end
                    if (run[i] < 100000) run[i]++;
                end else begin
                    run[i] = 0;
                    blk[i] = 1'b0;
                end
            end
            if (nev > 0) begin
                if (!m_rv || accept) begin
                    m_rv  = 1'b1;
                    r.ch  = first;
                    r.cyc = fcyc;
                    sbq.push_back(r);
                    if (nev > 1) m_ovf = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (accept) begin
                m_rv = 1'b0;
            end
        end
    end

    // Monitor: compare flags every cycle, pop the expected report on each handshake.
    always @(negedge clk_i) begin
        logic [NUM_CH-1:0] bv;
        rpt_t e;
        if (mon_en) begin
            for (int i = 0; i < NUM_CH; i++) bv[i] = blk[i];
            chk("block_sigs", 32'(axis_block_sigs_o), 32'(bv));
            chk("report_valid", 32'(report_valid_o), 32'(m_rv));
            chk("report_ovf", 32'(report_ovf_o), 32'(m_ovf));
            if (report_valid_o && report_ready_i) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL handshake: report accepted with no expected entry at %0t", $time);
                end else begin
                    e = sbq.pop_front();
                    chk("accepted_ch", 32'(report_ch_o), 32'(e.ch));
                    chk("accepted_cycles", 32'(report_cycles_o), 32'(e.cyc));
                end
            end else if (sbq.size() > 0 && report_valid_o) begin
                chk("held_ch", 32'(report_ch_o), 32'(sbq[0].ch));
                chk("held_cycles", 32'(report_cycles_o), 32'(sbq[0].cyc));
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle_all();
        tvalid_i = '0;
        tready_i = '0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    initial begin
        rst_ni         = 1'b0;
        tvalid_i       = '0;
        tready_i       = '0;
        inst_idle_i    = 1'b0;
        thresh_i       = 4'd4;
        clear_i        = 1'b0;
        report_ready_i = 1'b0;
        step();
        step();
        chk("reset_sigs", 32'(axis_block_sigs_o), 32'd0);
        chk("reset_valid", 32'(report_valid_o), 32'd0);
        chk("reset_ovf", 32'(report_ovf_o), 32'd0);
        rst_ni = 1'b1;
        mon_en = 1'b1;

        // thr=4, source stall on ch0
        thresh_i = 4'd4;
        do_clear();
        tvalid_i[0] = 1'b1;
        repeat (4) step();
        chk("p1_before_block", 32'(axis_block_sigs_o), 32'd0);
        step();
        chk("p1_block_sigs", 32'(axis_block_sigs_o), 32'h1);
        chk("p1_valid", 32'(report_valid_o), 32'd1);
        chk("p1_ch", 32'(report_ch_o), 32'd0);
        chk("p1_cycles", 32'(report_cycles_o), 32'd4);

        // transfer in the middle of the stall restarts the count
        idle_all();
        do_clear();
        tvalid_i[0] = 1'b1;
        repeat (3) step();
        tready_i[0] = 1'b1;
        step();
        tready_i[0] = 1'b0;
        repeat (3) step();
        chk("p2_sigs", 32'(axis_block_sigs_o), 32'd0);
        chk("p2_valid", 32'(report_valid_o), 32'd0);

        // simultaneous sink stalls on ch1 and ch3
        idle_all();
        do_clear();
        tready_i[1] = 1'b1;
        tready_i[3] = 1'b1;
        repeat (5) step();
        chk("p3_sigs", 32'(axis_block_sigs_o), 32'hA);
        chk("p3_ch", 32'(report_ch_o), 32'd1);
        chk("p3_cycles", 32'(report_cycles_o), 32'd4);
        chk("p3_ovf", 32'(report_ovf_o), 32'd1);

        // second event while the report is held
        tvalid_i[2] = 1'b1;
        repeat (5) step();
        chk("p4_sigs", 32'(axis_block_sigs_o), 32'hE);
        chk("p4_ch", 32'(report_ch_o), 32'd1);
        chk("p4_valid", 32'(report_valid_o), 32'd1);
        report_ready_i = 1'b1;
        step();
        chk("p4_accept_valid", 32'(report_valid_o), 32'd0);
        report_ready_i = 1'b0;

        // saturation at the counter maximum
        idle_all();
        thresh_i = 4'd15;
        do_clear();
        tvalid_i[0] = 1'b1;
        repeat (40) step();
        chk("p5_ch", 32'(report_ch_o), 32'd0);
        chk("p5_cycles", 32'(report_cycles_o), 32'd15);
        chk("p5_sigs", 32'(axis_block_sigs_o), 32'h1);
        inst_idle_i = 1'b1;
        step();
        chk("p5_idle_sigs", 32'(axis_block_sigs_o), 32'd0);
        inst_idle_i = 1'b0;

        // asynchronous reset while blocked with a report pending
        repeat (20) step();
        rst_ni = 1'b0;
        #1;
        chk("p6_rst_sigs", 32'(axis_block_sigs_o), 32'd0);
        chk("p6_rst_valid", 32'(report_valid_o), 32'd0);
        chk("p6_rst_ch", 32'(report_ch_o), 32'd0);
        chk("p6_rst_cycles", 32'(report_cycles_o), 32'd0);
        chk("p6_rst_ovf", 32'(report_ovf_o), 32'd0);
        idle_all();
        thresh_i = 4'd0;
        step();
        rst_ni      = 1'b1;
        tvalid_i[0] = 1'b1;
        step();
        chk("p6_thr0_pre", 32'(axis_block_sigs_o), 32'd0);
        step();
        chk("p6_thr0_sigs", 32'(axis_block_sigs_o), 32'h1);
        chk("p6_thr0_cycles", 32'(report_cycles_o), 32'd1);
        idle_all();

        // randomized traffic
        thresh_i = 4'd3;
        for (int c = 0; c < 4000; c++) begin
            step();
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(9) == 0) begin
                    tvalid_i[i] = 1'($urandom_range(1));
                    tready_i[i] = 1'($urandom_range(1));
                end
            end
            inst_idle_i    = ($urandom_range(60) == 0);
            clear_i        = ($urandom_range(300) == 0);
            report_ready_i = ($urandom_range(3) == 0);
            if ($urandom_range(150) == 0) begin
                if ($urandom_range(1) == 0) thresh_i = CNT_W'($urandom_range(MAXC));
                else thresh_i = CNT_W'($urandom_range(5));
            end
            if ($urandom_range(1500) == 0) begin
                rst_ni = 1'b0;
                step();
                rst_ni = 1'b1;
            end
        end
        clear_i = 1'b0;
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
